// File: rtl/snake_body_engine.sv
// Snake body store: a shift register of segment coordinates advanced one cell per
// accepted move. It also provides a self-collision pulse and a registered segment read port.
module snake_body_engine #(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int X_W      = 5,
    parameter int Y_W      = 5,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int IDX_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             update_snake,
    input  logic             grow,
    input  logic             reset_game,
    input  logic [1:0]       direction,
    output logic [X_W-1:0]   head_x,
    output logic [Y_W-1:0]   head_y,
    output logic [IDX_W:0]   length,
    output logic [1:0]       heading,
    output logic             self_hit,
    output logic             busy,
    output logic             overrun,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [X_W-1:0]   rd_x,
    output logic [Y_W-1:0]   rd_y,
    output logic             rd_valid
);

    typedef enum logic [1:0] {S_LOAD, S_READY, S_MOVE, S_CHECK} state_t;

    localparam logic [X_W-1:0]   X_LAST   = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(GRID_H - 1);
    localparam logic [Y_W-1:0]   Y_INIT   = Y_W'(GRID_H / 2);
    localparam logic [IDX_W:0]   LEN_MAX  = (IDX_W + 1)'(MAX_LEN);
    localparam logic [IDX_W:0]   LEN_INIT = (IDX_W + 1)'(INIT_LEN);
    localparam logic [1:0]       HEAD_INIT = 2'b01;

    // Initial body extends leftwards from the grid centre, wrapping in x if needed.
    function automatic logic [X_W-1:0] init_x(input int i);
        return X_W'(((GRID_W / 2 - i) % GRID_W + GRID_W) % GRID_W);
    endfunction

    state_t           state_q, state_d;
    logic [X_W-1:0]   seg_x_q [MAX_LEN];
    logic [X_W-1:0]   seg_x_d [MAX_LEN];
    logic [Y_W-1:0]   seg_y_q [MAX_LEN];
    logic [Y_W-1:0]   seg_y_d [MAX_LEN];
    logic [IDX_W:0]   length_q, length_d;
    logic [1:0]       heading_q, heading_d;
    logic             grow_q, grow_d;
    logic             overrun_q, overrun_d;
    logic [X_W-1:0]   rd_x_q;
    logic [Y_W-1:0]   rd_y_q;
    logic             rd_valid_q;
    logic [X_W-1:0]   next_x;
    logic [Y_W-1:0]   next_y;
    logic             body_hit;
    logic             rd_in_range;

    // Next head cell with explicit wrap so non-power-of-two grids behave.
    always_comb begin
        next_x = seg_x_q[0];
        next_y = seg_y_q[0];
        case (heading_q)
            2'b00:   next_y = (seg_y_q[0] == '0) ? Y_LAST : seg_y_q[0] - Y_W'(1);
            2'b01:   next_x = (seg_x_q[0] == X_LAST) ? '0 : seg_x_q[0] + X_W'(1);
            2'b10:   next_y = (seg_y_q[0] == Y_LAST) ? '0 : seg_y_q[0] + Y_W'(1);
            default: next_x = (seg_x_q[0] == '0) ? X_LAST : seg_x_q[0] - X_W'(1);
        endcase
    end

    always_comb begin
        body_hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if (((IDX_W + 1)'(i) < length_q) &&
                (seg_x_q[i] == seg_x_q[0]) && (seg_y_q[i] == seg_y_q[0])) begin
                body_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        seg_x_d   = seg_x_q;
        seg_y_d   = seg_y_q;
        length_d  = length_q;
        heading_d = heading_q;
        grow_d    = grow_q;
        overrun_d = overrun_q;

        if (update_snake && (state_q != S_READY)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_LOAD: begin
                state_d = S_READY;
            end
            S_READY: begin
                if (update_snake) begin
                    grow_d  = grow;
                    state_d = S_MOVE;
                    if (direction != (heading_q ^ 2'b10)) begin
                        heading_d = direction;
                    end
                end
            end
            S_MOVE: begin
                for (int i = 1; i < MAX_LEN; i++) begin
                    seg_x_d[i] = seg_x_q[i-1];
                    seg_y_d[i] = seg_y_q[i-1];
                end
                seg_x_d[0] = next_x;
                seg_y_d[0] = next_y;
                if (grow_q && (length_q < LEN_MAX)) begin
                    length_d = length_q + (IDX_W + 1)'(1);
                end
                state_d = S_CHECK;
            end
            default: begin
                state_d = S_READY;
            end
        endcase

        // Game restart overrides whatever the FSM was doing, including a pending move.
        if (reset_game) begin
            state_d   = S_LOAD;
            length_d  = LEN_INIT;
            heading_d = HEAD_INIT;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_d[i] = init_x(i);
                seg_y_d[i] = Y_INIT;
            end
        end
    end

    assign rd_in_range = ({1'b0, rd_idx} < LEN_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_LOAD;
            length_q   <= LEN_INIT;
            heading_q  <= HEAD_INIT;
            grow_q     <= 1'b0;
            overrun_q  <= 1'b0;
            rd_x_q     <= '0;
            rd_y_q     <= '0;
            rd_valid_q <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= init_x(i);
                seg_y_q[i] <= Y_INIT;
            end
        end else begin
            state_q    <= state_d;
            length_q   <= length_d;
            heading_q  <= heading_d;
            grow_q     <= grow_d;
            overrun_q  <= overrun_d;
            seg_x_q    <= seg_x_d;
            seg_y_q    <= seg_y_d;
            rd_valid_q <= ({1'b0, rd_idx} < length_q);
            rd_x_q     <= rd_in_range ? seg_x_q[rd_idx] : '0;
            rd_y_q     <= rd_in_range ? seg_y_q[rd_idx] : '0;
        end
    end

    assign head_x   = seg_x_q[0];
    assign head_y   = seg_y_q[0];
    assign length   = length_q;
    assign heading  = heading_q;
    assign self_hit = (state_q == S_CHECK) && body_hit;
    assign busy     = (state_q != S_READY);
    assign overrun  = overrun_q;
    assign rd_x     = rd_x_q;
    assign rd_y     = rd_y_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: directed and random moves compared against a
// queue-based model of the snake body.
module tb_snake_body_engine;

    localparam int GRID_W   = 32;
    localparam int GRID_H   = 24;
    localparam int X_W      = 5;
    localparam int Y_W      = 5;
    localparam int MAX_LEN  = 16;
    localparam int INIT_LEN = 3;
    localparam int IDX_W    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             update_snake;
    logic             grow;
    logic             reset_game;
    logic [1:0]       direction;
    logic [X_W-1:0]   head_x;
    logic [Y_W-1:0]   head_y;
    logic [IDX_W:0]   length;
    logic [1:0]       heading;
    logic             self_hit;
    logic             busy;
    logic             overrun;
    logic [IDX_W-1:0] rd_idx;
    logic [X_W-1:0]   rd_x;
    logic [Y_W-1:0]   rd_y;
    logic             rd_valid;

    snake_body_engine #(
        .GRID_W(GRID_W), .GRID_H(GRID_H), .X_W(X_W), .Y_W(Y_W),
        .MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .update_snake(update_snake), .grow(grow),
        .reset_game(reset_game), .direction(direction),
        .head_x(head_x), .head_y(head_y), .length(length), .heading(heading),
        .self_hit(self_hit), .busy(busy), .overrun(overrun),
        .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: body as a list of cells, head first, always MAX_LEN entries deep.
    int mq_x[$];
    int mq_y[$];
    int m_len;
    int m_head;
    logic last_hit;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        mq_x.delete();
        mq_y.delete();
        for (int i = 0; i < MAX_LEN; i++) begin
            mq_x.push_back(((GRID_W / 2 - i) % GRID_W + GRID_W) % GRID_W);
            mq_y.push_back(GRID_H / 2);
        end
        m_len  = INIT_LEN;
        m_head = 1;
    endfunction

    function automatic logic model_move(input int dir, input int g);
        int nx, ny;
        logic hit;
        if (dir != (m_head + 2) % 4) m_head = dir;
        nx = mq_x[0];
        ny = mq_y[0];
        case (m_head)
            0: ny = (ny + GRID_H - 1) % GRID_H;
            1: nx = (nx + 1) % GRID_W;
            2: ny = (ny + 1) % GRID_H;
            default: nx = (nx + GRID_W - 1) % GRID_W;
        endcase
        mq_x.push_front(nx);
        mq_y.push_front(ny);
        void'(mq_x.pop_back());
        void'(mq_y.pop_back());
        if (g != 0 && m_len < MAX_LEN) m_len++;
        hit = 1'b0;
        for (int i = 1; i < m_len; i++)
            if (mq_x[i] == mq_x[0] && mq_y[i] == mq_y[0]) hit = 1'b1;
        return hit;
    endfunction

    task automatic check_state();
        chk("head_x", 32'(head_x), mq_x[0]);
        chk("head_y", 32'(head_y), mq_y[0]);
        chk("length", 32'(length), m_len);
        chk("heading", 32'(heading), m_head);
    endtask

    task automatic do_move(input int dir, input int g, input bit late_update);
        logic exp_hit;
        update_snake = 1'b1;
        direction    = 2'(dir);
        grow         = g[0];
        tick();
        update_snake = late_update;
        direction    = 2'($urandom_range(0, 3));
        grow         = 1'($urandom_range(0, 1));
        exp_hit      = model_move(dir, g);
        chk("busy_move", 32'(busy), 1);
        tick();
        update_snake = 1'b0;
        check_state();
        chk("self_hit", 32'(self_hit), 32'(exp_hit));
        last_hit = self_hit;
        tick();
        chk("self_hit_clear", 32'(self_hit), 0);
        chk("busy_ready", 32'(busy), 0);
    endtask

    task automatic check_read(input int idx);
        rd_idx = IDX_W'(idx);
        tick();
        chk("rd_valid", 32'(rd_valid), (idx < m_len) ? 1 : 0);
        chk("rd_x", 32'(rd_x), mq_x[idx]);
        chk("rd_y", 32'(rd_y), mq_y[idx]);
    endtask

    task automatic restart();
        reset_game = 1'b1;
        tick();
        reset_game = 1'b0;
        tick();
        model_reset();
        chk("restart_ready", 32'(busy), 0);
    endtask

    initial begin
        rst = 1'b1; update_snake = 1'b0; grow = 1'b0; reset_game = 1'b0;
        direction = 2'b00; rd_idx = '0; last_hit = 1'b0;
        model_reset();
        tick(); tick();
        chk("rst_busy", 32'(busy), 1);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_self_hit", 32'(self_hit), 0);
        check_state();

        rst = 1'b0;
        tick();
        chk("ready_after_rst", 32'(busy), 0);
        check_state();
        check_read(1);
        check_read(3);

        for (int k = 0; k < 3; k++) begin
            do_move(1, 0, 1'b0);
            tick();
        end
        chk("head_x_19", 32'(head_x), 19);

        for (int k = 0; k < 7; k++) do_move(0, 0, 1'b0);
        for (int k = 0; k < 12; k++) do_move(1, 0, 1'b0);
        chk("head_x_31", 32'(head_x), 31);
        do_move(1, 0, 1'b0);
        chk("wrap_right_x", 32'(head_x), 0);
        chk("wrap_right_y", 32'(head_y), 5);
        for (int k = 0; k < 4; k++) do_move(1, 0, 1'b0);
        for (int k = 0; k < 5; k++) do_move(0, 0, 1'b0);
        chk("head_y_0", 32'(head_y), 0);
        do_move(0, 0, 1'b0);
        chk("wrap_up_x", 32'(head_x), 4);
        chk("wrap_up_y", 32'(head_y), 23);

        do_move(1, 0, 1'b0);
        do_move(3, 0, 1'b0);
        chk("reverse_kept", 32'(heading), 1);
        chk("reverse_x", 32'(head_x), 6);
        do_move(0, 0, 1'b0);
        chk("turn_up", 32'(heading), 0);

        restart();
        do_move(1, 1, 1'b0);
        do_move(1, 1, 1'b0);
        do_move(2, 0, 1'b0);
        do_move(3, 0, 1'b0);
        do_move(0, 0, 1'b0);
        chk("self_hit_directed", 32'(last_hit), 1);

        restart();
        for (int k = 0; k < 14; k++) do_move($urandom_range(0, 3), 1, 1'b0);
        chk("len_saturated", 32'(length), 16);
        do_move($urandom_range(0, 3), 1, 1'b0);
        do_move($urandom_range(0, 3), 1, 1'b0);
        check_read(15);

        restart();
        for (int k = 0; k < 40; k++) begin
            do_move($urandom_range(0, 3), ($urandom_range(0, 2) == 0) ? 1 : 0, 1'b0);
            if (k % 4 == 0) check_read($urandom_range(0, MAX_LEN - 1));
        end

        chk("overrun_before", 32'(overrun), 0);
        do_move($urandom_range(0, 3), 0, 1'b1);
        chk("overrun_set", 32'(overrun), 1);
        reset_game = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        model_reset();
        chk("rg_busy", 32'(busy), 1);
        check_state();
        chk("rg_overrun", 32'(overrun), 1);
        reset_game = 1'b0;
        tick();
        chk("rg_ready", 32'(busy), 0);
        check_read(2);

        do_move(2, 1, 1'b0);
        update_snake = 1'b1;
        direction    = 2'b10;
        tick();
        update_snake = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_state();
        chk("arst_busy", 32'(busy), 1);
        chk("arst_self_hit", 32'(self_hit), 0);
        chk("arst_overrun", 32'(overrun), 0);
        chk("arst_rd_valid", 32'(rd_valid), 0);
        chk("arst_rd_x", 32'(rd_x), 0);
        chk("arst_rd_y", 32'(rd_y), 0);
        rst = 1'b0;
        tick();
        chk("arst_ready", 32'(busy), 0);
        do_move(0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/snake_body_engine.md
Name: snake_body_engine

Overview:
- Holds the snake's segment coordinates on the play grid and advances them on every move pulse from the game controller FSM.
- Consumes the FSM's update_snake, score_inc, reset_game and latched direction.
- Produces head position, length, a self-collision flag for the collision detector, and a registered segment read port for the renderer.

Parameters:
- GRID_W, 32, grid width in cells.
- GRID_H, 24, grid height in cells.
- X_W, 5, x coordinate width; must satisfy 2**X_W >= GRID_W.
- Y_W, 5, y coordinate width; must satisfy 2**Y_W >= GRID_H.
- MAX_LEN, 16, segment storage depth, i.e. the maximum snake length.
- INIT_LEN, 3, length after reset or game restart; must satisfy 1 <= INIT_LEN <= MAX_LEN.
- IDX_W, 4, segment index / length width; must satisfy 2**IDX_W >= MAX_LEN, and length uses IDX_W+1 bits.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- update_snake  in  1  one-cycle move request
- grow  in  1  sampled with update_snake; tail is kept on this move (wired to score_inc)
- reset_game  in  1  level; restores the initial body while high
- direction  in  2  requested heading: 00 up, 01 right, 10 down, 11 left
- head_x  out  X_W  current head x
- head_y  out  Y_W  current head y
- length  out  IDX_W+1  number of valid segments
- heading  out  2  accepted heading
- self_hit  out  1  one-cycle pulse: new head overlaps its own body
- busy  out  1  high when not in READY
- overrun  out  1  sticky; an update_snake was dropped
- rd_idx  in  IDX_W  segment index to read (0 = head)
- rd_x  out  X_W  x of segment rd_idx, registered
- rd_y  out  Y_W  y of segment rd_idx, registered
- rd_valid  out  1  registered: rd_idx < length

Behaviour:
- Reset (rst=1, asynchronous) forces the following:
  - State LOAD, with segment i = (GRID_W/2 - i, GRID_H/2) for i < MAX_LEN, computed modulo GRID_W.
  - length=INIT_LEN, heading=01.
  - self_hit=0, overrun=0, rd_x=0, rd_y=0, rd_valid=0.
  - busy=1.
- States: LOAD, READY, MOVE, CHECK.
- LOAD:
  - Holds the reset body, length and heading each cycle while reset_game=1.
  - When reset_game=0, goes to READY next cycle.
  - overrun is cleared only by rst.
- READY:
  - On update_snake=1, latch grow and go to MOVE.
  - reset_game=1 in any state has priority: go to LOAD next cycle and drop any pending move.
- Direction acceptance is evaluated on the update_snake cycle:
  - If direction is the exact opposite of heading (00<->10, 01<->11), heading is kept.
  - Otherwise heading <= direction.
  - direction is ignored outside the update cycle.
- MOVE (one cycle):
  - seg[i] <= seg[i-1] for i = 1..MAX_LEN-1.
  - seg[0] <= head stepped one cell in the accepted heading. Up means y-1.
- Wrap-around rules:
  - x = GRID_W-1 stepping right gives 0; x = 0 stepping left gives GRID_W-1.
  - The same applies to y with GRID_H.
  - No modulo by power of two is allowed unless GRID equals 2**W.
- Growth:
  - If latched grow=1, length <= min(length+1, MAX_LEN).
  - At MAX_LEN, the move proceeds and the tail is discarded.
- CHECK (one cycle):
  - self_hit=1 for this single cycle iff seg[0] equals seg[i] for some 1 <= i < length, using the post-move length.
  - Then go to READY.
  - Move-to-flag latency: update_snake at cycle T gives positions updated at T+2 and self_hit at T+2.
- While busy=1, update_snake is ignored and sets overrun=1. It is not queued.
- head_x/head_y are always seg[0].
- Read port:
  - rd_x/rd_y/rd_valid are registered, with one-cycle latency from rd_idx.
  - Valid in every state.
  - Reads during MOVE return the pre-shift contents.
  - rd_idx >= MAX_LEN returns rd_valid=0 and coordinates 0.

Test Plan:
- Release rst with reset_game=0 -> READY after 1 cycle; head=(16,12); rd_idx=1 reads (15,12) one cycle later; rd_idx=3 gives rd_valid=0; length=3.
- Send 3 update_snake pulses with direction=01, 4 cycles apart -> head=(19,12), length=3, self_hit never asserted.
- From head (31,5) heading right, update -> head (0,5). From (4,0) heading up, update -> (4,23).
- With heading=01, request direction=11 on update -> heading stays 01 and head x+1. Request 00 -> heading 00 and y-1.
- Grow on 14 consecutive updates from length 3 -> length saturates at 16; the 16th-segment tail is discarded thereafter.
- Grow to length 5, then turn down, left, up on successive updates -> self_hit single-cycle pulse 2 cycles after the final update_snake.
- update_snake on the cycle after an accepted update -> dropped, overrun=1. Then reset_game=1 for 5 cycles -> body restored, length=3, overrun stays 1; READY one cycle after reset_game falls.
- Assert rst asynchronously during MOVE -> all outputs immediately at their reset values.
